// File: rtl/perm_pkg.sv
// Shared definitions for the permutation encoder/decoder pair.
// Provides the slice geometry, the rho offset table and the pi
// source-index function, so both ends of the round trip agree.
// It also holds the decoder FSM state type.
package perm_pkg;

    localparam int unsigned SLICE_W  = 25;
    localparam int unsigned N_SLICES = 64;
    localparam int unsigned Z_W      = 6;
    localparam int unsigned CNT_W    = 7;

    // Rho offsets indexed by slice bit 5*y+x
    localparam logic [Z_W-1:0] RHO [SLICE_W] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    // Encoded-slice bit that holds decoded lane (x,y): D[y][(2x+3y) mod 5]
    function automatic int unsigned pi_src(input int unsigned x, input int unsigned y);
        return 5 * ((2 * x + 3 * y) % 5) + y;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/inv_slice_map.sv
// Combinational inverse pi/rho map for one output slice.
// Ports:
//   i_buf   - full 64x25 encoded state
//   i_z     - output slice index
//   o_slice - decoded 25-bit slice z
module inv_slice_map
    import perm_pkg::*;
(
    input  logic [N_SLICES-1:0][SLICE_W-1:0] i_buf,
    input  logic [Z_W-1:0]                   i_z,
    output logic [SLICE_W-1:0]               o_slice
);

    for (genvar gy = 0; gy < 5; gy++) begin : g_y
        for (genvar gx = 0; gx < 5; gx++) begin : g_x
            localparam int unsigned OUT_IDX = 5 * gy + gx;
            localparam int unsigned SRC_IDX = pi_src(gx, gy);

            // Slice address wraps naturally in 6 bits
            logic [Z_W-1:0] w_zsrc;
            assign w_zsrc           = i_z + RHO[OUT_IDX];
            assign o_slice[OUT_IDX] = i_buf[w_zsrc][SRC_IDX];
        end
    end

endmodule

// File: rtl/inverse_permutation_func.sv
// Decoder: loads a 64x25 encoded state from synchronous memory, then
// streams 64 decoded slices, one write pulse every two cycles.
// Ports:
//   clk, rst (sync, active-low), start (level launch)
//   rd_addr/rd_data - memory read port, data one cycle after address
//   write_enable/write_value - pulsed output slice stream, z order
//   done - high after completion until start is seen low
module inverse_permutation_func
    import perm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [Z_W-1:0]     rd_addr,
    input  logic [SLICE_W-1:0] rd_data,
    output logic               write_enable,
    output logic [SLICE_W-1:0] write_value,
    output logic               done
);

    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(N_SLICES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SLICES - 1);
    localparam logic [Z_W-1:0]   ADDR_MAX = Z_W'(N_SLICES - 1);

    state_e                          r_state;
    logic [CNT_W-1:0]                r_cnt;
    logic                            r_phase;
    logic [Z_W-1:0]                  r_rd_addr;
    logic                            r_we;
    logic [SLICE_W-1:0]              r_wv;
    logic                            r_done;
    logic [N_SLICES-1:0][SLICE_W-1:0] r_buf;

    state_e                          w_state_nxt;
    logic [CNT_W-1:0]                w_cnt_nxt;
    logic                            w_phase_nxt;
    logic [Z_W-1:0]                  w_rd_addr_nxt;
    logic                            w_we_nxt;
    logic [SLICE_W-1:0]              w_wv_nxt;
    logic                            w_done_nxt;
    logic                            w_cap_en;
    logic [Z_W-1:0]                  w_cap_slot;
    logic [SLICE_W-1:0]              w_slice;

    inv_slice_map u_map (
        .i_buf   (r_buf),
        .i_z     (r_cnt[Z_W-1:0]),
        .o_slice (w_slice)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_phase_nxt   = r_phase;
        w_rd_addr_nxt = '0;
        w_we_nxt      = 1'b0;
        w_wv_nxt      = r_wv;
        w_done_nxt    = 1'b0;
        w_cap_en      = 1'b0;
        w_cap_slot    = Z_W'(r_cnt - CNT_W'(1));

        unique case (r_state)
            IDLE: begin
                w_cnt_nxt   = '0;
                w_phase_nxt = 1'b0;
                w_wv_nxt    = '0;
                if (start) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                // r_cnt = address issued last cycle; its data lands now at slot cnt-1
                w_cap_en      = (r_cnt != '0);
                w_cnt_nxt     = r_cnt + CNT_W'(1);
                w_rd_addr_nxt = (r_cnt < CNT_LAST) ? Z_W'(r_cnt + CNT_W'(1)) : ADDR_MAX;
                if (r_cnt == CNT_END) begin
                    w_state_nxt   = EMIT;
                    w_cnt_nxt     = '0;
                    w_phase_nxt   = 1'b0;
                    w_rd_addr_nxt = '0;
                end
            end
            EMIT: begin
                // r_cnt is the word index z; reaching 64 means the last low cycle has passed
                if (r_cnt == CNT_END) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else if (!r_phase) begin
                    w_we_nxt    = 1'b1;
                    w_wv_nxt    = w_slice;
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                w_done_nxt = 1'b1;
                w_cnt_nxt  = '0;
                if (!start) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
            r_rd_addr <= '0;
            r_we      <= 1'b0;
            r_wv      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_phase   <= w_phase_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_we      <= w_we_nxt;
            r_wv      <= w_wv_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Slice buffer; contents are don't-care across reset
    always_ff @(posedge clk) begin
        if (rst && w_cap_en) begin
            r_buf[w_cap_slot] <= rd_data;
        end
    end

    assign rd_addr      = r_rd_addr;
    assign write_enable = r_we;
    assign write_value  = r_wv;
    assign done         = r_done;

endmodule
